// File: rtl/clken_divider.sv
// clken_divider: multi-channel clock-enable generator. Enables stay gated until
// the clock source has been locked for a settle period. Ratio writes are taken
// immediately when safe, otherwise deferred to the channel's period boundary.
module clken_divider #(
    parameter int unsigned Nch        = 4,
    parameter int unsigned Wdiv       = 16,
    parameter int unsigned DIV_INIT   = 8,
    parameter int unsigned START_LOG2 = 2,
    localparam int unsigned Wch       = (Nch > 1) ? $clog2(Nch) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            locked,
    input  logic            wr,
    input  logic [Wch-1:0]  wr_ch,
    input  logic [Wdiv-1:0] wr_div,
    input  logic            resync,
    output logic            ready,
    output logic [Nch-1:0]  ce,
    output logic [Nch-1:0]  pending
);

    localparam int unsigned Wst = START_LOG2 + 1;
    localparam int unsigned Wc  = Wdiv + 1;
    localparam logic [Wst-1:0] ST_FULL = Wst'(2 ** START_LOG2);

    logic [Wst-1:0]            r_st, w_st_d;
    logic                      r_ready, w_ready_d;
    logic [Nch-1:0][Wdiv-1:0]  r_act, w_act_d;
    logic [Nch-1:0][Wdiv-1:0]  r_cnt, w_cnt_d;
    logic [Nch-1:0][Wdiv-1:0]  r_pnd, w_pnd_d;
    logic [Nch-1:0]            r_pend, w_pend_d;
    logic [Nch-1:0]            r_ce, w_ce_d;
    logic [Nch-1:0]            w_hit, w_wrap, w_act_nz;

    // Settle counter: saturates at full count; any unlocked edge restarts it
    always_comb begin
        if (!locked) begin
            w_st_d = '0;
        end else if (r_st == ST_FULL) begin
            w_st_d = r_st;
        end else begin
            w_st_d = r_st + Wst'(1);
        end
        w_ready_d = (w_st_d == ST_FULL);
    end

    // Per-channel write decode and period-boundary (wrap) detection
    for (genvar gi = 0; gi < Nch; gi++) begin : g_ch
        // Out-of-range channel indices match no channel and are dropped
        assign w_hit[gi]    = wr && (wr_ch == Wch'(gi));
        assign w_act_nz[gi] = (r_act[gi] != '0);
        // Wrap compare in Wdiv+1 bits so the maximum ratio cannot overflow
        assign w_wrap[gi]   = w_ready_d && w_act_nz[gi] &&
                              (({1'b0, r_cnt[gi]} + Wc'(1)) == {1'b0, r_act[gi]});
    end

    // Next state of counters, ratios, deferred updates and enables
    always_comb begin
        w_act_d  = r_act;
        w_cnt_d  = r_cnt;
        w_pnd_d  = r_pnd;
        w_pend_d = r_pend;
        w_ce_d   = '0;
        for (int i = 0; i < Nch; i++) begin
            if (w_ready_d && w_act_nz[i]) begin
                w_ce_d[i]  = (r_cnt[i] == '0);
                w_cnt_d[i] = w_wrap[i] ? '0 : r_cnt[i] + Wdiv'(1);
            end else begin
                w_cnt_d[i] = '0;
            end
            if (w_wrap[i] && r_pend[i]) begin
                w_act_d[i]  = r_pnd[i];
                w_pend_d[i] = 1'b0;
                w_cnt_d[i]  = '0;
            end
            // A write is safe to apply now if no period is in flight
            if (w_hit[i]) begin
                if (!w_act_nz[i] || !w_ready_d || w_wrap[i]) begin
                    w_act_d[i]  = wr_div;
                    w_cnt_d[i]  = '0;
                    w_pend_d[i] = 1'b0;
                end else begin
                    w_pnd_d[i]  = wr_div;
                    w_pend_d[i] = 1'b1;
                end
            end
            if (resync && w_ready_d) begin
                w_cnt_d[i] = '0;
                w_ce_d[i]  = 1'b0;
            end
        end
    end

    // State registers; every output comes straight from a flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st    <= '0;
            r_ready <= 1'b0;
            r_act   <= {Nch{Wdiv'(DIV_INIT)}};
            r_cnt   <= '0;
            r_pnd   <= '0;
            r_pend  <= '0;
            r_ce    <= '0;
        end else begin
            r_st    <= w_st_d;
            r_ready <= w_ready_d;
            r_act   <= w_act_d;
            r_cnt   <= w_cnt_d;
            r_pnd   <= w_pnd_d;
            r_pend  <= w_pend_d;
            r_ce    <= w_ce_d;
        end
    end

    assign ready   = r_ready;
    assign ce      = r_ce;
    assign pending = r_pend;

endmodule

// File: tb/tb_clken_divider.sv
// Testbench for clken_divider: directed scenarios plus random traffic, all
// checked every cycle against a phase-arithmetic reference model.
module tb_clken_divider;

    localparam int NCH        = 4;
    localparam int WDIV       = 16;
    localparam int DIV_INIT   = 8;
    localparam int START_LOG2 = 2;
    localparam int FULL       = 1 << START_LOG2;

    logic            clk;
    logic            reset;
    logic            locked;
    logic            wr;
    logic [1:0]      wr_ch;
    logic [WDIV-1:0] wr_div;
    logic            resync;
    logic            ready;
    logic [NCH-1:0]  ce;
    logic [NCH-1:0]  pending;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    clken_divider #(
        .Nch        (NCH),
        .Wdiv       (WDIV),
        .DIV_INIT   (DIV_INIT),
        .START_LOG2 (START_LOG2)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .locked  (locked),
        .wr      (wr),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .resync  (resync),
        .ready   (ready),
        .ce      (ce),
        .pending (pending)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a channel's phase at edge t is (t - base) mod ratio,
    // where base is the edge at which the channel's period last restarted.
    int m_act  [NCH];
    int m_pnd  [NCH];
    int m_base [NCH];
    bit m_pend [NCH];
    bit m_ce   [NCH];
    bit m_rdy;
    int m_run;
    int m_t;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_act[i]  = DIV_INIT;
            m_pnd[i]  = 0;
            m_pend[i] = 1'b0;
            m_ce[i]   = 1'b0;
            m_base[i] = m_t + 1;
        end
        m_rdy = 1'b0;
        m_run = 0;
    endfunction

    function automatic void model_edge(bit lk, bit w, int ch, int div, bit rs);
        bit rn;
        bit wrap;
        int ph;
        int old;
        m_t++;
        m_run = lk ? m_run + 1 : 0;
        rn    = lk && (m_run >= FULL);
        for (int i = 0; i < NCH; i++) begin
            old  = m_act[i];
            ph   = (old != 0) ? (m_t - m_base[i]) % old : 0;
            wrap = rn && (old != 0) && (ph == old - 1);
            m_ce[i] = rn && (old != 0) && (ph == 0) && !rs;
            if (!rn || old == 0 || wrap) m_base[i] = m_t + 1;
            if (wrap && m_pend[i]) begin
                m_act[i]  = m_pnd[i];
                m_pend[i] = 1'b0;
            end
            if (w && ch == i) begin
                if (old == 0 || !rn || wrap) begin
                    m_act[i]  = div;
                    m_pend[i] = 1'b0;
                    m_base[i] = m_t + 1;
                end else begin
                    m_pnd[i]  = div;
                    m_pend[i] = 1'b1;
                end
            end
            if (rs && rn) m_base[i] = m_t + 1;
        end
        m_rdy = rn;
    endfunction

    task automatic step();
        logic [NCH-1:0] e_ce;
        logic [NCH-1:0] e_pd;
        @(posedge clk);
        model_edge(locked, wr, int'(wr_ch), int'(wr_div), resync);
        #1;
        for (int i = 0; i < NCH; i++) begin
            e_ce[i] = m_ce[i];
            e_pd[i] = m_pend[i];
        end
        check_eq("ready", 32'(ready), 32'(m_rdy));
        check_eq("ce", 32'(ce), 32'(e_ce));
        check_eq("pending", 32'(pending), 32'(e_pd));
    endtask

    task automatic apply_write(input int ch, input int div);
        wr     = 1'b1;
        wr_ch  = 2'(ch);
        wr_div = WDIV'(div);
        step();
        wr     = 1'b0;
    endtask

    // Asserts reset between edges and checks outputs drop with no clock edge
    task automatic async_reset();
        #1 reset = 1'b0;
        #1;
        check_eq("async_rst_ready", 32'(ready), 32'd0);
        check_eq("async_rst_ce", 32'(ce), 32'd0);
        check_eq("async_rst_pending", 32'(pending), 32'd0);
        model_reset();
        #1 reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        locked = 1'b1;
        wr     = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
        resync = 1'b0;
        m_t    = 0;
        model_reset();
        #2;
        check_eq("reset_ready", 32'(ready), 32'd0);
        check_eq("reset_ce", 32'(ce), 32'd0);
        check_eq("reset_pending", 32'(pending), 32'd0);
        #6 reset = 1'b1;

        // Settle: ready and the first aligned pulse on the 4th locked edge
        repeat (3) step();
        check_eq("ready_before_settle", 32'(ready), 32'd0);
        step();
        check_eq("ready_at_settle", 32'(ready), 32'd1);
        check_eq("first_ce_aligned", 32'(ce), 32'hF);
        step();

        // ch1 <- 3 while its counter is at 2: deferred to the wrap
        apply_write(1, 3);
        check_eq("pending_ch1_deferred", 32'(pending), 32'h2);
        repeat (5) step();
        check_eq("pending_cleared_at_wrap", 32'(pending), 32'd0);
        step();
        check_eq("period8_aligned", 32'(ce), 32'hF);
        repeat (3) step();
        check_eq("ch1_period3", 32'(ce), 32'h2);

        // ch2 <- 0 stops after the current period; ch2 <- 1 applies at once
        apply_write(2, 0);
        check_eq("pending_ch2_zero", 32'(pending), 32'h4);
        repeat (4) step();
        check_eq("ch2_stopped", 32'(ce), 32'h9);
        apply_write(2, 1);
        check_eq("ch2_immediate_no_pending", 32'(pending), 32'd0);
        step();
        check_eq("ch2_every_cycle_a", 32'(ce[2]), 32'd1);
        step();
        check_eq("ch2_every_cycle_b", 32'(ce[2]), 32'd1);

        // Two writes to ch0 in one period: only the last one lands
        apply_write(0, 5);
        apply_write(0, 12);
        check_eq("ch0_pending_two_writes", 32'(pending[0]), 32'd1);
        repeat (2) step();
        check_eq("ch0_pending_applied", 32'(pending[0]), 32'd0);
        step();
        check_eq("ch0_boundary_pulse", 32'(ce[0]), 32'd1);
        repeat (10) step();
        // This edge is ch0's wrap edge for ratio 12
        apply_write(0, 4);
        check_eq("wrap_edge_write_no_pending", 32'(pending[0]), 32'd0);
        step();
        check_eq("wrap_edge_write_pulse", 32'(ce[0]), 32'd1);

        // Ratios 2,3,5,8 then resync
        apply_write(0, 2);
        apply_write(1, 3);
        apply_write(2, 5);
        apply_write(3, 8);
        repeat (20) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        check_eq("resync_edge_ce_low", 32'(ce), 32'd0);
        step();
        check_eq("resync_all_aligned", 32'(ce), 32'hF);
        repeat (30) step();

        // One-cycle lock loss: full settle period repeats, ratios kept
        locked = 1'b0;
        step();
        check_eq("unlock_ready_low", 32'(ready), 32'd0);
        check_eq("unlock_ce_low", 32'(ce), 32'd0);
        locked = 1'b1;
        repeat (3) step();
        check_eq("relock_not_yet_ready", 32'(ready), 32'd0);
        step();
        check_eq("relock_ready", 32'(ready), 32'd1);
        check_eq("relock_ce_aligned", 32'(ce), 32'hF);
        repeat (20) step();

        // Reset while a pulse is high; ratios return to DIV_INIT
        for (int k = 0; k < 4 && ce == '0; k++) step();
        async_reset();
        repeat (4) step();
        check_eq("post_reset_ce_aligned", 32'(ce), 32'hF);
        repeat (8) step();
        check_eq("post_reset_period8", 32'(ce), 32'hF);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            locked = ($urandom_range(0, 199) != 0);
            wr     = ($urandom_range(0, 5) == 0);
            wr_ch  = 2'($urandom_range(0, 3));
            wr_div = WDIV'($urandom_range(0, 9));
            resync = ($urandom_range(0, 49) == 0);
            step();
            if ($urandom_range(0, 499) == 0) async_reset();
        end
        wr     = 1'b0;
        resync = 1'b0;
        locked = 1'b1;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clken_divider.md
# clken_divider

Parametrised multi-channel clock-enable generator: one fast clock in, `Nch` independent single-cycle enable pulses out, each at a runtime-programmable divide ratio. It replaces fixed MMCM output dividers for slow logic domains (CPU at 1/8, peripherals at 1/N). It gates all outputs until the upstream clock source reports lock for a programmable settling period. Ratio changes are glitch-free, applied at period boundaries, and all channels can be phase-aligned on demand.

## Interface
- `Nch`, 4, number of enable channels (≥1)
- `Wdiv`, 16, divide-ratio width; ratio range 0..2^Wdiv-1
- `DIV_INIT`, 8, reset ratio loaded into every channel
- `START_LOG2`, 2, `ready` requires `locked` high for 2^START_LOG2 consecutive cycles

- `clk`  in  1  fast clock (100 MHz); all state on posedge
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- `locked`  in  1  clock-source lock indication (synchronous to `clk`)
- `wr`  in  1  ratio write strobe, one cycle
- `wr_ch`  in  $clog2(Nch) (min 1)  channel index for write; out-of-range index ignored
- `wr_div`  in  Wdiv  new ratio; 0 = channel disabled
- `resync`  in  1  one-cycle pulse: realign all channel counters
- `ready`  out  1  settle period complete, enables live
- `ce`  out  Nch  per-channel enable pulse, registered
- `pending`  out  Nch  channel has a deferred ratio update queued

## Operation
- Per channel: active ratio `act[i]`, counter `cnt[i]` (Wdiv bits), pending ratio `pnd[i]`, flag `pending[i]`.
- Reset (`reset`=0): `ready`=0, `ce`=0, `pending`=0, `cnt`=0, `act`=DIV_INIT, start counter=0.
- Settle counter: increments each edge with `locked`=1 and not saturated; any edge sampling `locked`=0 clears it and `ready` at that edge. `ready` is 1 from the edge where the counter reaches 2^START_LOG2.
- While `ready`=0 (its next value): `cnt`←0, `ce`←0.
- While `ready`=1 and no `resync`: `ce[i]`←(`act[i]`≠0)&(`cnt[i]`==0); `cnt[i]`←0 if `cnt[i]`+1==`act[i]` (computed in Wdiv+1 bits) else `cnt[i]`+1. `act[i]`=0: `cnt[i]` held 0, `ce[i]`=0.
- Ratio N≥1 → `ce[i]` high exactly 1 of every N cycles; N=1 → `ce[i]` continuously high.
- `resync` sampled 1 (with `ready`=1): all `cnt`←0, all `ce`←0 that edge; next edge all enabled channels pulse together.
- Write (`wr`=1, valid `wr_ch`=c):
  - If `act[c]`=0, or `ready`=0, or this edge is a wrap edge for c: `act[c]`←`wr_div`, `cnt[c]`←0, `pending[c]`←0 (overrides any older pending value).
  - Otherwise: `pnd[c]`←`wr_div`, `pending[c]`←1; a later write before the boundary overwrites `pnd[c]`.
- Wrap edge with `pending[i]`=1: `act[i]`←`pnd[i]`, `pending[i]`←0, `cnt[i]`←0. Writing 0 therefore stops `ce[i]` only after the current period completes.
- `resync` and write on same edge: write rules apply to `act`, then counters zeroed; pending updates still wait for a wrap.
- `locked` dropping mid-operation: `ready`, `ce` fall at that edge; `act` and `pending` preserved; on re-lock, full settle period repeats.

## Timing
- All outputs registered; no combinational path input→output.
- `locked` rising before edge k (held high): `ready`=1 after edge k+2^START_LOG2−1; the same edge produces the first `ce` on every enabled channel (aligned).
- `ce` latency from `resync`: 0 at edge k, 1 at edge k+1.
- Immediate write: first `ce[c]` with new ratio one edge after the write edge.
- Asynchronous reset: outputs 0 without clock; deassertion takes effect at the next edge.

## Test plan
- Reset, `locked`=1 from cycle 0, defaults (Nch=4, DIV_INIT=8, START_LOG2=2) → `ready` after 4th edge, all four `ce` pulse together, then every 8 cycles; `pending`=0.
- Write ch1=3 mid-period (`cnt[1]`=2) → `pending[1]`=1 until wrap at `cnt`=7, then `ce[1]` every 3 cycles; other channels unaffected.
- Write ch2=0 then ch2=1 → `ce[2]` stops after current period; the second write applies immediately; `ce[2]` high every cycle from the next edge.
- Two writes to ch0 (5 then 12) within one period → only 12 applied at boundary; write landing exactly on a wrap edge applies without `pending`.
- Ratios 2,3,5,8 then `resync` → all `ce` 0 that edge, all 1 next edge, then independent periods.
- `locked` low for one cycle mid-run → `ready`/`ce` 0 at that edge, recover 4 edges after re-lock with ratios intact; `reset`=0 mid-pulse → `ce` 0 asynchronously, `act`=8.
